uart_tx_pacer: RTL and testbench

//  Flow-controlled byte feeder upstream of jtag_uart's TX side. Applications push bytes on a valid/ready port.

---
 rtl/uart_tx_pacer.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_pacer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_pacer.sv
// uart_tx_pacer
//   Flow-controlled byte feeder for the jtag_uart TX side. Bytes arrive on a
//   valid/ready port and are buffered in a small FIFO. Each byte is replayed
//   as a setup / strobe / hold sequence on the active-low write strobe.
//   A new byte is launched only while the UART reports that its TX buffer
//   has room (txfl low).
//
//   Optional feature macro: UART_TX_CRLF_EN
//     When defined, a CR (0x0D) is sent in front of every LF (0x0A) taken
//     from the FIFO. When undefined, bytes pass through unchanged and none of
//     the CR bookkeeping exists.
module uart_tx_pacer #(
   parameter int DEPTH_LOG2 = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  nreset_i,
   input  logic [7:0]            in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [7:0]            uart_data_o,
   output logic                  uart_nwr_o,
   input  logic                  uart_txfl_i,
   output logic                  busy_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic [CNT_W-1:0]      sent_count_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

   // Strobe sequencer states; nwr is low only while in S_STROBE.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t                state_reg;
   state_t                state_next;

   // FIFO storage and bookkeeping
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   level_reg;
   logic [7:0]            head;
   logic                  push;
   logic                  pop;

   // Registered UART-side outputs
   logic [7:0]            data_reg;
   logic [7:0]            data_next;
   logic                  nwr_reg;
   logic                  nwr_next;
   logic [CNT_W-1:0]      count_reg;
   logic [CNT_W-1:0]      count_next;

`ifdef UART_TX_CRLF_EN
   // cr_done: a CR has already been sent for the LF now at the FIFO head.
   // sending_cr: the byte currently in flight is an inserted CR, so the
   // HOLD state must not pop the FIFO.
   logic                  cr_done_reg;
   logic                  cr_done_next;
   logic                  sending_cr_reg;
   logic                  sending_cr_next;
`endif

   // Ready depends only on registered occupancy, so a full FIFO stays
   // not-ready even in the cycle it is being popped.
   assign in_ready_o = (level_reg != LEVEL_FULL);
   assign push       = in_valid_i & in_ready_o;
   assign head       = mem[rd_ptr_reg];

   assign uart_data_o  = data_reg;
   assign uart_nwr_o   = nwr_reg;
   assign level_o      = level_reg;
   assign sent_count_o = count_reg;
   assign busy_o       = (level_reg != '0) | (state_reg != S_IDLE);

   // FIFO storage write; contents need no reset because the pointers do.
   always_ff @(posedge clk_i) begin
      if (nreset_i && push) begin
         mem[wr_ptr_reg] <= in_data_i;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the depth.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_reg <= S_IDLE;
         data_reg  <= 8'h00;
         nwr_reg   <= 1'b1;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         nwr_reg   <= nwr_next;
         count_reg <= count_next;
      end
   end

`ifdef UART_TX_CRLF_EN
   // CR insertion flags.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         cr_done_reg    <= 1'b0;
         sending_cr_reg <= 1'b0;
      end else begin
         cr_done_reg    <= cr_done_next;
         sending_cr_reg <= sending_cr_next;
      end
   end
`endif

   // Next-state and next-output logic. nwr_next looks one state ahead so
   // the registered strobe is low exactly while the state is S_STROBE.
   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      nwr_next   = 1'b1;
      count_next = count_reg;
      pop        = 1'b0;
`ifdef UART_TX_CRLF_EN
      cr_done_next    = cr_done_reg;
      sending_cr_next = sending_cr_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            // txfl is only looked at here; a byte already launched always
            // runs to completion.
            if ((level_reg != '0) && !uart_txfl_i) begin
               state_next = S_SETUP;
`ifdef UART_TX_CRLF_EN
               if ((head == 8'h0A) && !cr_done_reg) begin
                  data_next       = 8'h0D;
                  sending_cr_next = 1'b1;
                  cr_done_next    = 1'b1;
               end else begin
                  data_next       = head;
                  sending_cr_next = 1'b0;
               end
`else
               data_next = head;
`endif
            end
         end
         S_SETUP: begin
            state_next = S_STROBE;
            nwr_next   = 1'b0;
         end
         S_STROBE: begin
            state_next = S_HOLD;
         end
         S_HOLD: begin
            state_next = S_IDLE;
            count_next = count_reg + 1'b1;
`ifdef UART_TX_CRLF_EN
            if (!sending_cr_reg) begin
               pop          = 1'b1;
               cr_done_next = 1'b0;
            end
`else
            pop = 1'b1;
`endif
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_pacer.sv
// tb_uart_tx_pacer
//   Directed stimulus for uart_tx_pacer. Every accepted push queues the bytes
//   expected on the UART; a monitor pops them on each write strobe.
module tb_uart_tx_pacer;

   localparam int DEPTH_LOG2 = 2;
   localparam int CNT_W      = 16;

   logic                clk = 1'b0;
   logic                nreset;
   logic [7:0]          in_data;
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          uart_data;
   logic                uart_nwr;
   logic                uart_txfl;
   logic                busy;
   logic [DEPTH_LOG2:0] level;
   logic [CNT_W-1:0]    sent_count;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         nstrobes = 0;
   int         exp_sent = 0;
   logic [7:0] exp_q[$];
   int         strobe_cyc[$];

   uart_tx_pacer #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i       (clk),
      .nreset_i    (nreset),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .uart_data_o (uart_data),
      .uart_nwr_o  (uart_nwr),
      .uart_txfl_i (uart_txfl),
      .busy_o      (busy),
      .level_o     (level),
      .sent_count_o(sent_count)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one line per observed strobe, compared against the scoreboard.
   initial begin
      logic [7:0] e;
      logic       prev_nwr;
      prev_nwr = 1'b1;
      forever begin
         @(negedge clk);
         if (nreset === 1'b1 && uart_nwr === 1'b0) begin
            chk("nwr_width", {31'd0, prev_nwr}, 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL strobe_unexpected actual=%02h required=none", uart_data);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_data", {24'd0, uart_data}, {24'd0, e});
               chk("strobe_count", {16'd0, sent_count}, 32'(exp_sent[15:0]));
               exp_sent++;
            end
            nstrobes++;
            strobe_cyc.push_back(cyc);
         end
         prev_nwr = uart_nwr;
      end
   end

   task automatic push_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("push_ready", {31'd0, in_ready}, 32'd1);
`ifdef UART_TX_CRLF_EN
      if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(b);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output int at);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < bound) begin
         tick();
         n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
      at = cyc;
   endtask

   // Returns in the cycle after the strobe (sequencer in S_HOLD).
   task automatic wait_strobe(input int bound);
      int n;
      int s0;
      n  = 0;
      s0 = nstrobes;
      while (nstrobes == s0 && n < bound) begin
         tick();
         n++;
      end
      chk("strobe_seen", nstrobes, s0 + 1);
   endtask

   initial begin
      int p;
      int at;
      int base;
      int s0;
      int d;
      int n;

      nreset    = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      uart_txfl = 1'b0;

      // 1: reset held two cycles with valid asserted
      tick();
      tick();
      chk("reset_nwr",   {31'd0, uart_nwr}, 32'd1);
      chk("reset_data",  {24'd0, uart_data}, 32'd0);
      chk("reset_level", {29'd0, level}, 32'd0);
      chk("reset_count", {16'd0, sent_count}, 32'd0);
      chk("reset_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_busy",  {31'd0, busy}, 32'd0);
      nreset   = 1'b1;
      in_valid = 1'b0;

      // 2: four back-to-back pushes, pacing and latency
      base = strobe_cyc.size();
      push_byte(8'h41);
      p = cyc;
      push_byte(8'h42);
      push_byte(8'h43);
      push_byte(8'h44);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      chk("full_level", {29'd0, level}, 32'd4);
      tick();
      chk("pop_level", {29'd0, level}, 32'd3);
      chk("pop_ready", {31'd0, in_ready}, 32'd1);
      wait_idle(60, at);
      chk("latency", strobe_cyc[base] - p, 32'd2);
      for (int i = 1; i < 4; i++) begin
         chk("pace", strobe_cyc[base+i] - strobe_cyc[base+i-1], 32'd4);
      end
      chk("busy_fall", at, strobe_cyc[base+3] + 2);
      chk("count_after_4", {16'd0, sent_count}, 32'd4);

      // 3: txfl blocks launch; release latency; txfl raised mid-byte
      uart_txfl = 1'b1;
      s0 = nstrobes;
      push_byte(8'h51);
      push_byte(8'h52);
      repeat (20) tick();
      chk("txfl_block_strobes", nstrobes, s0);
      chk("txfl_block_level", {29'd0, level}, 32'd2);
      uart_txfl = 1'b0;
      d = cyc;
      wait_strobe(10);
      chk("txfl_release_latency", strobe_cyc[strobe_cyc.size()-1] - d, 32'd2);
      uart_txfl = 1'b1;
      repeat (10) tick();
      chk("txfl_hold_level", {29'd0, level}, 32'd1);
      chk("txfl_hold_strobes", nstrobes, s0 + 1);
      uart_txfl = 1'b0;
      wait_idle(40, at);
      chk("count_after_6", {16'd0, sent_count}, 32'd6);

      // 4: simultaneous push and pop at level 2, then pointer wrap
      uart_txfl = 1'b1;
      push_byte(8'h21);
      push_byte(8'h22);
      uart_txfl = 1'b0;
      wait_strobe(10);
      in_data  = 8'h23;
      in_valid = 1'b1;
      chk("pushpop_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(8'h23);
      tick();
      in_valid = 1'b0;
      chk("pushpop_level", {29'd0, level}, 32'd2);
      for (int i = 0; i < 10; i++) begin
         push_byte(8'h70 + 8'(i));
      end
      wait_idle(200, at);
      chk("count_after_wrap", {16'd0, sent_count}, 32'd19);

      // 5: reset during S_STROBE aborts and flushes
      push_byte(8'h81);
      push_byte(8'h82);
      n = 0;
      while (uart_nwr !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      chk("strobe5_seen", {31'd0, uart_nwr}, 32'd0);
      @(negedge clk);
      #1;
      nreset = 1'b0;
      tick();
      chk("abort_nwr",   {31'd0, uart_nwr}, 32'd1);
      chk("abort_level", {29'd0, level}, 32'd0);
      chk("abort_count", {16'd0, sent_count}, 32'd0);
      chk("abort_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_busy",  {31'd0, busy}, 32'd0);
      exp_q.delete();
      exp_sent = 0;
      nreset   = 1'b1;
      s0 = nstrobes;
      repeat (12) tick();
      chk("abort_no_strobe", nstrobes, s0);
      chk("abort_count_stays", {16'd0, sent_count}, 32'd0);

      // 6: LF handling (CR inserted only with the feature enabled)
      push_byte(8'h61);
      push_byte(8'h0A);
      wait_idle(60, at);
`ifdef UART_TX_CRLF_EN
      chk("crlf_count", {16'd0, sent_count}, 32'd3);
`else
      chk("lf_count", {16'd0, sent_count}, 32'd2);
`endif

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
